// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the load/store buffer,
// splitting each request into per-byte RAM cycles and assembling 32-bit results.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR} state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_cnt, w_cnt_next;
  logic [2:0]          r_n, w_n_next;
  logic                r_last_lsb, w_last_next;
  logic [ADDR_W-1:0]   r_base, w_base_next;
  logic [DATA_W-1:0]   r_wdata, w_wdata_next;
  logic [DATA_W-1:0]   r_buf, w_buf_next;
  logic                r_if_done, w_if_done_next;
  logic                r_lsb_done, w_lsb_done_next;
  logic [DATA_W-1:0]   r_if_data, w_if_data_next;
  logic [DATA_W-1:0]   r_lsb_rdata, w_lsb_rdata_next;
  logic [7:0]          r_din_save;
  logic                r_din_saved;

  logic                w_active, w_issue, w_io_stall, w_grant_lsb;
  logic [ADDR_W-1:0]   w_addr_i;
  logic [7:0]          w_din, w_wbyte;
  logic [2:0]          w_lsb_n;
  logic [DATA_W-1:0]   w_assembled;

  assign w_active   = (r_state != S_IDLE);
  assign w_issue    = w_active && (r_cnt < r_n);
  assign w_addr_i   = r_base + {{(ADDR_W-3){1'b0}}, r_cnt};
  // The I/O window is decoded from address bits 17:16, so ADDR_W must be at least 18.
  assign w_io_stall = (r_state == S_LS_WR) && (r_base[17:16] == 2'b11) && io_buffer_full;
  assign w_lsb_n    = (lsb_size == 2'b00) ? 3'd1 : (lsb_size == 2'b01) ? 3'd2 : 3'd4;

  // mem_din keeps tracking the held address while rdy is low, so the byte that was
  // in flight when the freeze began is kept aside and used on resume.
  assign w_din = r_din_saved ? r_din_save : mem_din;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_assembled[8*gi +: 8] = (r_cnt == 3'(gi + 1)) ? w_din : r_buf[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_wbyte = 8'h00;
    case (r_cnt[1:0])
      2'd0: w_wbyte = r_wdata[7:0];
      2'd1: w_wbyte = r_wdata[15:8];
      2'd2: w_wbyte = r_wdata[23:16];
      2'd3: w_wbyte = r_wdata[31:24];
      default: w_wbyte = 8'h00;
    endcase
  end

  assign mem_a     = w_issue ? w_addr_i : '0;
  assign mem_wr    = (r_state == S_LS_WR) && w_issue && rdy && !w_io_stall;
  assign mem_dout  = ((r_state == S_LS_WR) && w_issue) ? w_wbyte : 8'h00;
  assign if_done   = r_if_done;
  assign lsb_done  = r_lsb_done;
  assign if_data   = r_if_data;
  assign lsb_rdata = r_lsb_rdata;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_n_next         = r_n;
    w_last_next      = r_last_lsb;
    w_base_next      = r_base;
    w_wdata_next     = r_wdata;
    w_buf_next       = r_buf;
    w_if_done_next   = 1'b0;
    w_lsb_done_next  = 1'b0;
    w_if_data_next   = r_if_data;
    w_lsb_rdata_next = r_lsb_rdata;
    w_grant_lsb      = 1'b0;
    if (rdy) begin
      case (r_state)
        S_IDLE: begin
          // No accept while a done pulse is out, so a finishing requester is not re-granted.
          if (!flush && !r_if_done && !r_lsb_done && (if_req || lsb_req)) begin
            w_grant_lsb = lsb_req && (!if_req || !r_last_lsb);
            w_cnt_next  = 3'd0;
            w_buf_next  = '0;
            w_last_next = w_grant_lsb;
            if (w_grant_lsb) begin
              w_state_next = lsb_we ? S_LS_WR : S_LS_RD;
              w_base_next  = lsb_addr;
              w_n_next     = w_lsb_n;
              w_wdata_next = lsb_wdata;
            end else begin
              w_state_next = S_IF_RD;
              w_base_next  = if_addr;
              w_n_next     = 3'd4;
            end
          end
        end
        S_IF_RD, S_LS_RD: begin
          if (flush) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 3'd0;
          end else begin
            if (r_cnt != 3'd0) w_buf_next = w_assembled;
            if (r_cnt == r_n) begin
              w_state_next = S_IDLE;
              w_cnt_next   = 3'd0;
              if (r_state == S_IF_RD) begin
                w_if_done_next = 1'b1;
                w_if_data_next = w_assembled;
              end else begin
                w_lsb_done_next  = 1'b1;
                w_lsb_rdata_next = w_assembled;
              end
            end else begin
              w_cnt_next = r_cnt + 3'd1;
            end
          end
        end
        S_LS_WR: begin
          if (!w_io_stall) begin
            if (r_cnt == r_n - 3'd1) begin
              w_state_next    = S_IDLE;
              w_cnt_next      = 3'd0;
              w_lsb_done_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 3'd1;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_last_lsb  <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= '0;
      r_lsb_rdata <= '0;
      r_din_save  <= 8'h00;
      r_din_saved <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_n         <= w_n_next;
      r_last_lsb  <= w_last_next;
      r_base      <= w_base_next;
      r_wdata     <= w_wdata_next;
      r_buf       <= w_buf_next;
      r_if_done   <= w_if_done_next;
      r_lsb_done  <= w_lsb_done_next;
      r_if_data   <= w_if_data_next;
      r_lsb_rdata <= w_lsb_rdata_next;
      if (!rdy) begin
        if (!r_din_saved) begin
          r_din_save  <= mem_din;
          r_din_saved <= 1'b1;
        end
      end else begin
        r_din_saved <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM model with one-cycle read latency,
// expected results queued at request time and checked when a done pulse appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, io_buffer_full;
  logic        if_req, lsb_req, lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] if_addr, lsb_addr, lsb_wdata;
  logic        if_done, lsb_done, mem_wr;
  logic [31:0] if_data, lsb_rdata, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;

  logic [7:0]  ram [0:262143];
  logic [31:0] if_q[$];
  logic [32:0] lsb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_done) begin
      check("if_done_expected", if_q.size(), (if_q.size() != 0) ? if_q.size() : 1);
      if (if_q.size() != 0) begin
        logic [31:0] e;
        e = if_q.pop_front();
        check("if_data", if_data, e);
        $display("[%0t] IF   read  data=%08h", $time, if_data);
      end
    end
    if (lsb_done) begin
      check("lsb_done_expected", lsb_q.size(), (lsb_q.size() != 0) ? lsb_q.size() : 1);
      if (lsb_q.size() != 0) begin
        logic [32:0] e;
        e = lsb_q.pop_front();
        if (e[32]) check("lsb_rdata", lsb_rdata, e[31:0]);
        $display("[%0t] LSB %s data=%08h", $time, e[32] ? "load " : "store", lsb_rdata);
      end
    end
  end

  task automatic run_txn(input bit is_if, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int n, lat;
    bit seen;
    logic [31:0] sh;
    n   = is_if ? 4 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
    lat = (is_if || !we) ? n + 1 : n;
    if (is_if) begin
      if_q.push_back(exp);
      if_addr = addr;
      if_req  = 1'b1;
    end else begin
      lsb_q.push_back({!we, exp});
      lsb_we = we; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
      lsb_req = 1'b1;
    end
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k <= n) begin
        check("mem_a", mem_a, addr + 32'(k - 1));
        if (!is_if && we) begin
          sh = wdata >> (8 * (k - 1));
          check("mem_wr", {31'd0, mem_wr}, 32'd1);
          check("mem_dout", {24'd0, mem_dout}, {24'd0, sh[7:0]});
        end
      end
      if (is_if ? if_done : lsb_done) begin
        seen = 1'b1;
        check("latency", k - 1, lat);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    if_req = 1'b0; lsb_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hits, nd, cnt_if, cnt_ls, lat;
    bit prev_done, seen;
    logic [3:0] ord;

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'b00;
    if_addr = '0; lsb_addr = '0; lsb_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_if_done", {31'd0, if_done}, 0);
    check("rst_lsb_done", {31'd0, lsb_done}, 0);
    check("rst_if_data", if_data, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_mem_dout", {24'd0, mem_dout}, 0);
    rst = 1'b1;
    {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]} = 32'h00000513;
    {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]} = 32'hAABBCCDD;
    {ram[1], ram[0], ram[18'h3FFFF], ram[18'h3FFFE]} = 32'h12345678;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 32'h00000513);
    run_txn(1'b0, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 32'h0);
    check("store_word_ram", ram_word(32'h1000), 32'hDEADBEEF);
    run_txn(1'b0, 1'b0, 2'b01, 32'h1002, 32'h0, 32'h0000DEAD);
    run_txn(1'b0, 1'b0, 2'b00, 32'h1001, 32'h0, 32'h000000BE);
    run_txn(1'b0, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, 32'h12345678);

    // Tie from reset: both requests held, LSB wins first, then alternation.
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    if_addr = 32'h100; lsb_we = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h200;
    if_q.push_back(32'h00000513); lsb_q.push_back({1'b1, 32'hAABBCCDD});
    if_req = 1'b1; lsb_req = 1'b1;
    nd = 0; cnt_if = 0; cnt_ls = 0; prev_done = 1'b0; ord = 4'h0;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      @(negedge clk);
      if (prev_done) check("no_grant_on_done", mem_a, 0);
      prev_done = if_done | lsb_done;
      if (lsb_done) begin
        ord[3 - nd] = 1'b1; nd++; cnt_ls++;
        if (cnt_ls >= 2) lsb_req = 1'b0; else lsb_q.push_back({1'b1, 32'hAABBCCDD});
      end
      if (if_done && nd < 4) begin
        ord[3 - nd] = 1'b0; nd++; cnt_if++;
        if (cnt_if >= 2) if_req = 1'b0; else if_q.push_back(32'h00000513);
      end
    end
    if_req = 1'b0; lsb_req = 1'b0;
    check("tie_done_count", nd, 4);
    check("grant_order_LILI", {28'd0, ord}, 32'hA);
    @(negedge clk);
    if_q.delete(); lsb_q.delete();

    // Flush at cnt=2 of a fetch: abort, no done, address issue stops.
    if_addr = 32'h100; if_req = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_at_cnt2_addr", mem_a, 32'h102);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_stops_issue", mem_a, 0);
    hits = 0;
    repeat (8) begin
      if (if_done) hits++;
      @(negedge clk);
    end
    check("flush_no_if_done", hits, 0);

    // Flush at cnt=1 of a word store is ignored.
    lsb_q.push_back({1'b0, 32'h0});
    lsb_we = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h2000; lsb_wdata = 32'h11223344; lsb_req = 1'b1;
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      flush = (k == 2);
      if (lsb_done) begin seen = 1'b1; lat = k - 1; end
    end
    flush = 1'b0; lsb_req = 1'b0;
    check("flush_store_latency", lat, 4);
    check("flush_store_ram", ram_word(32'h2000), 32'h11223344);
    @(negedge clk);

    // I/O back-pressure on a byte store to the I/O window.
    lsb_q.push_back({1'b0, 32'h0});
    io_buffer_full = 1'b1;
    lsb_we = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h41; lsb_req = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        check("io_stall_mem_wr", {31'd0, mem_wr}, 0);
        check("io_stall_addr_hold", mem_a, 32'h30000);
      end
      if (k == 4) begin
        io_buffer_full = 1'b0;
        #1;
        check("io_release_mem_wr", {31'd0, mem_wr}, 1);
        check("io_release_dout", {24'd0, mem_dout}, 32'h41);
      end
      if (lsb_done) begin seen = 1'b1; check("io_done_latency", k - 1, 4); end
    end
    if (!seen) check("io_done_timeout", 0, 1);
    lsb_req = 1'b0; io_buffer_full = 1'b0;
    check("io_store_ram", {24'd0, ram[18'h30000]}, 32'h41);
    @(negedge clk);

    // rdy low for two cycles during a word load at cnt=1.
    lsb_q.push_back({1'b1, 32'hDEADBEEF});
    lsb_we = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h1000; lsb_req = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (k == 2) begin check("rdy_cnt1_addr", mem_a, 32'h1001); rdy = 1'b0; end
      if (k == 3 || k == 4) begin
        check("rdy_freeze_addr", mem_a, 32'h1001);
        check("rdy_no_done", {31'd0, lsb_done}, 0);
      end
      if (k == 4) rdy = 1'b1;
      if (lsb_done) begin seen = 1'b1; check("rdy_latency", k - 1, 7); end
    end
    if (!seen) check("rdy_done_timeout", 0, 1);
    lsb_req = 1'b0; rdy = 1'b1;
    @(negedge clk);

    // Reset in the middle of a word store.
    lsb_we = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h3000; lsb_wdata = 32'hCAFEF00D; lsb_req = 1'b1;
    @(negedge clk);
    check("rst_store_wr_b0", {31'd0, mem_wr}, 1);
    @(negedge clk);
    check("rst_store_addr_b1", mem_a, 32'h3001);
    rst = 1'b0;
    #1;
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_mid_mem_a", mem_a, 0);
    lsb_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (lsb_done) hits++;
    end
    check("rst_no_lsb_done", hits, 0);
    check("rst_partial_ram", ram_word(32'h3000), 32'h0000000D);

    @(negedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("lsb_q_drained", lsb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
